// File: rtl/score_bcd_converter.sv
// rtl/score_bcd_converter.sv - iterative double-dabble binary-to-BCD converter for the score digit drawer
//
// Converts an unsigned binary score into NUM_DIGITS BCD digit indices, one
// input bit per clock. Results stay held between conversions so the drawer
// can sample them at any pixel.
//
// Ports:
//   clk        rising-edge system clock
//   reset      asynchronous active-high reset (aborts any conversion)
//   start      conversion request, honoured only while idle
//   bin_in     binary value, captured on the accepting edge
//   busy       high from the accepting edge until the edge that raises done
//   done       one-cycle pulse, new results valid
//   digits_out BCD digits, digit i at [4i+3:4i], digit 0 least significant
//   blank_mask bit i set = digit i is a leading zero (bit 0 never set)
//   overflow   last value exceeded 10^NUM_DIGITS-1 (digits saturate to 9s)

module score_bcd_converter #(
  parameter int BIN_WIDTH  = 16,
  parameter int NUM_DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [BIN_WIDTH-1:0]    bin_in,
  output logic                    busy,
  output logic                    done,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [NUM_DIGITS-1:0]   blank_mask,
  output logic                    overflow
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = (BIN_WIDTH > 1) ? $clog2(BIN_WIDTH) : 1;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0]           MAX_VAL   = pow10(NUM_DIGITS) - 64'd1;
  // Reset display is a single "0": only digit 0 is shown.
  localparam logic [NUM_DIGITS-1:0] BLANK_RST = ~(NUM_DIGITS'(1));

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nxt;

  logic [BIN_WIDTH-1:0]  bin_reg;
  logic [BCD_W-1:0]      bcd_reg;
  logic [CNT_W-1:0]      cnt;
  logic                  ovf_pending;
  logic                  accept;
  logic [BCD_W-1:0]      bcd_adj;
  logic [BCD_W-1:0]      bcd_shifted;
  logic [BIN_WIDTH-1:0]  bin_shifted;
  logic [NUM_DIGITS-1:0] blank_calc;
  logic [63:0]           bin_ext;

  assign bin_ext = 64'(bin_in);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT:   if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Add-3 correction uses the pre-shift nibble values, all digits in parallel.
  always_comb begin
    bcd_adj = bcd_reg;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_reg[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_reg[4*i +: 4] + 4'd3;
    end
    bcd_shifted = {bcd_adj[BCD_W-2:0], bin_reg[BIN_WIDTH-1]};
    bin_shifted = {bin_reg[BIN_WIDTH-2:0], 1'b0};
  end

  // A digit is blank when it and every more significant digit are zero.
  always_comb begin
    logic all_zero;
    all_zero   = 1'b1;
    blank_calc = '0;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      all_zero      = all_zero & (bcd_reg[4*i +: 4] == 4'd0);
      blank_calc[i] = all_zero;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bin_reg     <= '0;
      bcd_reg     <= '0;
      cnt         <= '0;
      ovf_pending <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      digits_out  <= '0;
      blank_mask  <= BLANK_RST;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            bin_reg     <= bin_in;
            bcd_reg     <= '0;
            cnt         <= CNT_W'(BIN_WIDTH - 1);
            ovf_pending <= (bin_ext > MAX_VAL);
            busy        <= 1'b1;
          end
        end
        SHIFT: begin
          bcd_reg <= bcd_shifted;
          bin_reg <= bin_shifted;
          cnt     <= cnt - CNT_W'(1);
        end
        DONE: begin
          busy <= 1'b0;
          done <= 1'b1;
          if (ovf_pending) begin
            // BCD register holds truncated garbage here; saturate instead.
            digits_out <= {NUM_DIGITS{4'h9}};
            blank_mask <= '0;
            overflow   <= 1'b1;
          end else begin
            digits_out <= bcd_reg;
            blank_mask <= blank_calc;
            overflow   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
